prime_gen: RTL and testbench

//   Sequential prime generator: the producing counterpart to the combinational prime detector.
//   On start it emits every prime p with 2 <= p <= limit, in ascending order, over a valid/ready stream.

---
 rtl/prime_pkg.sv | 15 +
 rtl/mod_unit.sv | 65 ++++++
 rtl/prime_gen.sv | 128 ++++++++++++
 tb/tb_prime_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared types and constants for the sequential prime generator.
package prime_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        EMIT,
        NEXT,
        FIN
    } prime_state_t;

endpackage

// File: rtl/mod_unit.sv
// Restoring remainder unit: one quotient bit per cycle, rem valid with the rdy pulse.
module mod_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             rdy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [CntW-1:0]  cnt_q;
    logic             active_q;
    logic             rdy_q;

    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;

    // Trial < 2*divisor, so the subtracted value always fits in WIDTH bits.
    always_comb begin
        trial    = {rem_q, dvd_q[WIDTH-1]};
        trial_ge = (trial >= {1'b0, dsr_q});
        rem_next = trial_ge ? (trial[WIDTH-1:0] - dsr_q) : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (go) begin
                dvd_q    <= dividend;
                dsr_q    <= divisor;
                rem_q    <= '0;
                cnt_q    <= CntW'(WIDTH);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= rem_next;
                dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    active_q <= 1'b0;
                    rdy_q    <= 1'b1;
                end
            end
        end
    end

    assign rem = rem_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/prime_gen.sv
// Streams every prime in [2, limit] in ascending order using trial division
// against a shared multi-cycle remainder unit.
module prime_gen
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] prime,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic             busy,
    output logic             done
);

    prime_state_t     state_q;
    logic [WIDTH-1:0] lim_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] prime_q;
    logic             prime_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [2*WIDTH-1:0] d_ext;
    logic [2*WIDTH-1:0] cand_ext;
    logic [2*WIDTH-1:0] sq;
    logic               sq_gt_cand;
    logic               mod_go;
    logic [WIDTH-1:0]   mod_rem;
    logic               mod_rdy;

    // Double-width square: d*d > cand ends the search without d ever overflowing.
    always_comb begin
        d_ext      = {{WIDTH{1'b0}}, d_q};
        cand_ext   = {{WIDTH{1'b0}}, cand_q};
        sq         = d_ext * d_ext;
        sq_gt_cand = (sq > cand_ext);
        mod_go     = (state_q == CHECK) && !sq_gt_cand;
    end

    mod_unit #(
        .WIDTH (WIDTH)
    ) u_mod_unit (
        .clk      (clk),
        .rst      (rst),
        .go       (mod_go),
        .dividend (cand_q),
        .divisor  (d_q),
        .rem      (mod_rem),
        .rdy      (mod_rdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lim_q         <= '0;
            cand_q        <= '0;
            d_q           <= '0;
            prime_q       <= '0;
            prime_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done_q) begin
                        lim_q   <= limit;
                        cand_q  <= WIDTH'(2);
                        d_q     <= WIDTH'(2);
                        busy_q  <= 1'b1;
                        state_q <= (limit < WIDTH'(2)) ? FIN : CHECK;
                    end
                end
                CHECK: begin
                    state_q <= sq_gt_cand ? EMIT : DIV;
                end
                DIV: begin
                    if (mod_rdy) begin
                        if (mod_rem == '0) begin
                            state_q <= NEXT;
                        end else begin
                            d_q     <= d_q + WIDTH'(1);
                            state_q <= CHECK;
                        end
                    end
                end
                EMIT: begin
                    if (!prime_valid_q) begin
                        prime_q       <= cand_q;
                        prime_valid_q <= 1'b1;
                    end else if (prime_ready) begin
                        prime_valid_q <= 1'b0;
                        state_q       <= NEXT;
                    end
                end
                NEXT: begin
                    if ((cand_q == lim_q) || (&cand_q)) begin
                        state_q <= FIN;
                    end else begin
                        cand_q  <= cand_q + WIDTH'(1);
                        d_q     <= WIDTH'(2);
                        state_q <= CHECK;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prime       = prime_q;
    assign prime_valid = prime_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_prime_gen.sv
// Directed bench for prime_gen: 16-bit instance for the main scenarios, 8-bit for the wrap case.
module tb_prime_gen;
    import prime_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel8;
    logic [15:0] limit;
    logic        ready;

    logic [15:0] p16;
    logic        pv16, busy16, done16;
    logic [7:0]  p8;
    logic        pv8, busy8, done8;
    logic        start16, start8;
    logic [7:0]  limit8;

    logic [15:0] prime_s;
    logic        pv_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;

    int  got[$];
    int  first_valid, done_cyc, busy_cycles;
    bit  stall;
    int  stall_prime;
    bit  found;
    bit  mono_ok;
    bit  all_prime;

    always #5 clk = ~clk;

    assign start16 = start & ~sel8;
    assign start8  = start & sel8;
    assign limit8  = limit[7:0];
    assign prime_s = sel8 ? {8'd0, p8} : p16;
    assign pv_s    = sel8 ? pv8 : pv16;
    assign busy_s  = sel8 ? busy8 : busy16;
    assign done_s  = sel8 ? done8 : done16;

    prime_gen #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .limit       (limit),
        .prime       (p16),
        .prime_valid (pv16),
        .prime_ready (ready),
        .busy        (busy16),
        .done        (done16)
    );

    prime_gen #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .limit       (limit8),
        .prime       (p8),
        .prime_valid (pv8),
        .prime_ready (ready),
        .busy        (busy8),
        .done        (done8)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_list(input string tag, input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
        end
    endtask

    // One run: pulse start, collect handshaken primes until done, then check the idle tail.
    task automatic run(input logic [15:0] lim, input bit rnd, input int inj_cyc);
        got.delete();
        first_valid = 0;
        done_cyc    = 0;
        busy_cycles = 0;
        stall       = 1'b0;
        @(negedge clk);
        limit = lim;
        start = 1'b1;
        for (int cyc = 1; cyc <= 20000 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start = (cyc == inj_cyc);
            if (start) limit = 16'd3;
            ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (stall) begin
                check("stall_valid", int'(pv_s), 1);
                check("stall_prime", int'(prime_s), stall_prime);
            end
            if (busy_s) busy_cycles++;
            if (pv_s && first_valid == 0) first_valid = cyc;
            if (pv_s && ready) got.push_back(int'(prime_s));
            stall       = pv_s && !ready;
            stall_prime = int'(prime_s);
            if (done_s) done_cyc = cyc;
        end
        start = 1'b0;
        ready = 1'b1;
        check("done_seen", int'(done_cyc != 0), 1);
        @(negedge clk);
        check("done_one_pulse", int'(done_s), 0);
        check("busy_after", int'(busy_s), 0);
        check("valid_after", int'(pv_s), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel8  = 1'b0;
        limit = '0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_prime16", int'(p16), 0);
        check("rst_valid16", int'(pv16), 0);
        check("rst_busy16", int'(busy16), 0);
        check("rst_done16", int'(done16), 0);
        check("rst_valid8", int'(pv8), 0);
        rst = 1'b0;

        // limit=20, always ready
        run(16'd20, 1'b0, 0);
        check_list("lim20", '{2, 3, 5, 7, 11, 13, 17, 19});
        check("lim20_first_valid", first_valid, 3);

        // no primes for limit 1 and 0
        run(16'd1, 1'b0, 0);
        check("lim1_len", got.size(), 0);
        check("lim1_first_valid", first_valid, 0);
        check("lim1_done_cyc", done_cyc, 2);
        check("lim1_busy_cycles", busy_cycles, 1);
        run(16'd0, 1'b0, 0);
        check("lim0_len", got.size(), 0);
        check("lim0_done_cyc", done_cyc, 2);
        check("lim0_busy_cycles", busy_cycles, 1);

        run(16'd2, 1'b0, 0);
        check_list("lim2", '{2});
        run(16'd4, 1'b0, 0);
        check_list("lim4", '{2, 3});

        // back-pressure with random stalls
        run(16'd30, 1'b1, 0);
        check_list("lim30", '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29});

        // reset while dividing candidate 9
        @(negedge clk);
        limit = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (dut16.state_q == DIV && dut16.cand_q == 16'd9) found = 1'b1;
        end
        check("reach_div9", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_prime", int'(p16), 0);
        check("mid_rst_valid", int'(pv16), 0);
        check("mid_rst_busy", int'(busy16), 0);
        check("mid_rst_done", int'(done16), 0);
        check("mid_rst_state", int'(dut16.state_q), int'(IDLE));
        rst = 1'b0;
        run(16'd10, 1'b0, 0);
        check_list("lim10", '{2, 3, 5, 7});

        // 8-bit instance: full range, stray start mid-run
        sel8 = 1'b1;
        run(16'd255, 1'b0, 50);
        check("w8_len", got.size(), 54);
        if (got.size() > 0) begin
            check("w8_first", got[0], 2);
            check("w8_last", got[got.size() - 1], 251);
        end
        mono_ok   = 1'b1;
        all_prime = 1'b1;
        for (int i = 0; i < got.size(); i++) begin
            if (!is_prime(got[i])) all_prime = 1'b0;
            if (i > 0 && got[i] <= got[i - 1]) mono_ok = 1'b0;
        end
        check("w8_increasing", int'(mono_ok), 1);
        check("w8_all_prime", int'(all_prime), 1);
        repeat (3) @(negedge clk);
        check("w8_idle_busy", int'(busy8), 0);
        check("w8_idle_valid", int'(pv8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
